// File: rtl/dz_intr_arb_pkg.sv
// dz_intr_arb_pkg: shared types and helpers for the DZ11-style interrupt
// controller.
//   arb_state_e : arbiter states (IDLE=0, REQ=1, VECT=2, VECTCLR=3, DONE=4)
//   chan_state_e: per-channel states (IDLE=0, ACT=1, WAIT=2)
//   prio_sel()  : picks the first set bit of a mask, searching upward from a
//                 start index and wrapping modulo n.
package dz_intr_arb_pkg;

  localparam int MAX_CH = 16;
  localparam int SELW   = 4;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_REQ     = 3'd1,
    ARB_VECT    = 3'd2,
    ARB_VECTCLR = 3'd3,
    ARB_DONE    = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_ACT  = 2'd1,
    CH_WAIT = 2'd2
  } chan_state_e;

  // Wrapping search. start < n and n <= 16, so start+k < 32 and the wrapped
  // index (s - n) always fits in 4 bits; low-bit subtraction is exact there.
  function automatic logic [SELW-1:0] prio_sel(input logic [MAX_CH-1:0] mask,
                                               input logic [SELW-1:0]   start,
                                               input logic [4:0]        n);
    logic [SELW-1:0] sel;
    logic [SELW-1:0] j;
    logic [4:0]      s;
    logic            found;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      s = {1'b0, start} + 5'(k);
      j = (s >= n) ? (s[SELW-1:0] - n[SELW-1:0]) : s[SELW-1:0];
      if ((5'(k) < n) && !found && mask[j]) begin
        sel   = j;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dz_intr_arb_chan.sv
// dz_intr_chan: one interrupt channel, IDLE -> ACT -> WAIT -> IDLE.
//   clk, rst  : clock, async active-high reset
//   clr_i     : synchronous clear back to IDLE
//   en_i      : channel enable; low forces IDLE over everything else
//   irq_i     : level interrupt condition
//   done_i    : arbiter has finished the vector cycle for this channel
//   pend_o    : registered, high while the channel is in ACT
// WAIT holds until irq falls so one rising condition yields one interrupt.
module dz_intr_chan
  import dz_intr_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic irq_i,
  input  logic done_i,
  output logic pend_o
);

  chan_state_e state_q, state_d;
  logic        pend_q;

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = CH_IDLE;
    end else begin
      case (state_q)
        CH_IDLE: if (irq_i)  state_d = CH_ACT;
        CH_ACT:  if (done_i) state_d = CH_WAIT;
        CH_WAIT: if (!irq_i) state_d = CH_IDLE;
        default:             state_d = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CH_IDLE;
      pend_q  <= 1'b0;
    end else if (clr_i) begin
      state_q <= CH_IDLE;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= (state_d == CH_ACT);
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/dz_intr_arb.sv
// dz_intr_arb: N-channel interrupt controller with a shared bus arbiter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous device clear / bus INIT
//   en, irq  : per-channel enable and level interrupt condition
//   ack      : bus interrupt acknowledge
//   vect     : interrupt vector read cycle active
//   pend     : per-channel pending (channel in ACT)
//   req      : bus interrupt request (arbiter in REQ)
//   idx      : granted channel index, latched on ack
//   gnt      : arbiter in VECT or VECTCLR
// Build option INTR_ROUND_ROBIN_EN: round-robin grant starting after the
// last-served channel; otherwise fixed priority, lowest index wins.
module dz_intr_arb
  import dz_intr_arb_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int IDXW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [NCH-1:0]  en,
  input  logic [NCH-1:0]  irq,
  input  logic            ack,
  input  logic            vect,
  output logic [NCH-1:0]  pend,
  output logic            req,
  output logic [IDXW-1:0] idx,
  output logic            gnt
);

  arb_state_e        state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              req_q, gnt_q;
  logic [NCH-1:0]    pend_w, done_w;
  logic [MAX_CH-1:0] pend16;
  logic [SELW-1:0]   start_w, sel_w;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // done lasts exactly the single DONE cycle of the channel that won
    assign done_w[g] = (state_q == ARB_DONE) && (idx_q == IDXW'(g));

    dz_intr_chan u_chan (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (clr),
      .en_i   (en[g]),
      .irq_i  (irq[g]),
      .done_i (done_w[g]),
      .pend_o (pend_w[g])
    );
  end

  always_comb begin
    pend16             = '0;
    pend16[NCH-1:0]    = pend_w;
  end

`ifdef INTR_ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr_q;

  assign start_w = (ptr_q == IDXW'(NCH - 1)) ? '0 : SELW'(ptr_q) + SELW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                ptr_q <= '0;
    else if (clr)                                           ptr_q <= '0;
    else if (state_d == ARB_DONE && state_q != ARB_DONE)    ptr_q <= idx_q;
  end
`else
  assign start_w = '0;
`endif

  assign sel_w = prio_sel(pend16, start_w, 5'(NCH));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ARB_IDLE: if (|pend_w) state_d = ARB_REQ;
      ARB_REQ: begin
        // pending may have vanished (channel disabled) by ack: drop back
        if (ack) begin
          if (|pend_w) begin
            state_d = ARB_VECT;
            idx_d   = IDXW'(sel_w);
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_VECT:    if (vect)  state_d = ARB_VECTCLR;
      ARB_VECTCLR: if (!vect) state_d = ARB_DONE;
      ARB_DONE:               state_d = ARB_IDLE;
      default:                state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      req_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else if (clr) begin
      state_q <= ARB_IDLE;
      idx_q   <= '0;
      req_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      req_q   <= (state_d == ARB_REQ);
      gnt_q   <= (state_d == ARB_VECT) || (state_d == ARB_VECTCLR);
    end
  end

  assign pend = pend_w;
  assign req  = req_q;
  assign gnt  = gnt_q;
  assign idx  = idx_q;

endmodule

// File: tb/tb_dz_intr_arb.sv
// tb_dz_intr_arb: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural
// model of the channel/arbiter rules.
module tb_dz_intr_arb;
  localparam int NCH  = 4;
  localparam int IDXW = 2;

  logic            clk = 1'b0, rst = 1'b1, clr = 1'b0, ack = 1'b0, vect = 1'b0;
  logic [NCH-1:0]  en = '0, irq = '0;
  logic [NCH-1:0]  pend;
  logic            req, gnt;
  logic [IDXW-1:0] idx;

  int n_cmp = 0, n_bad = 0;

  dz_intr_arb #(.NCH(NCH), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .irq(irq), .ack(ack),
    .vect(vect), .pend(pend), .req(req), .idx(idx), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channel: "armed" (pending) or "served" (waiting for irq to fall).
  // Bus phase: where the ack/vector handshake currently is.
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_VECT = 2, PH_VCLR = 3, PH_DONE = 4;
  bit [NCH-1:0] m_act = '0, m_wait = '0;
  int m_ph = PH_IDLE, m_idx = 0;
`ifdef INTR_ROUND_ROBIN_EN
  int m_ptr = 0;
`endif

  function automatic int pick(input bit [NCH-1:0] m, input int start);
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = (start + k) % NCH;
      if (m[j]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst || clr) begin
      m_act = '0; m_wait = '0; m_ph = PH_IDLE; m_idx = 0;
`ifdef INTR_ROUND_ROBIN_EN
      m_ptr = 0;
`endif
    end else begin
      bit [NCH-1:0] pm;
      int dn;
      pm = m_act;
      dn = (m_ph == PH_DONE) ? m_idx : -1;
      for (int i = 0; i < NCH; i++) begin
        if (!en[i]) begin
          m_act[i] = 1'b0; m_wait[i] = 1'b0;
        end else if (m_act[i]) begin
          if (dn == i) begin m_act[i] = 1'b0; m_wait[i] = 1'b1; end
        end else if (m_wait[i]) begin
          if (!irq[i]) m_wait[i] = 1'b0;
        end else if (irq[i]) begin
          m_act[i] = 1'b1;
        end
      end
      case (m_ph)
        PH_IDLE: if (pm != 0) m_ph = PH_REQ;
        PH_REQ: if (ack) begin
          if (pm != 0) begin
`ifdef INTR_ROUND_ROBIN_EN
            m_idx = pick(pm, (m_ptr + 1) % NCH);
`else
            m_idx = pick(pm, 0);
`endif
            m_ph = PH_VECT;
          end else m_ph = PH_IDLE;
        end
        PH_VECT: if (vect) m_ph = PH_VCLR;
        PH_VCLR: if (!vect) begin
          m_ph = PH_DONE;
`ifdef INTR_ROUND_ROBIN_EN
          m_ptr = m_idx;
`endif
        end
        default: m_ph = PH_IDLE;
      endcase
    end
    #1;
    chk("cyc_pend", 32'(pend), 32'(m_act));
    chk("cyc_req",  32'(req),  32'(m_ph == PH_REQ));
    chk("cyc_gnt",  32'(gnt),  32'(m_ph == PH_VECT || m_ph == PH_VCLR));
    chk("cyc_idx",  32'(idx),  32'(m_idx));
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int t = 0;
    while (req !== 1'b1 && t < 20) begin step(); t++; end
    chk("req_timeout", 32'(req), 32'h1);
  endtask

  // full handshake; returns in the DONE cycle
  task automatic hs(output int got);
    wait_req();
    ack = 1'b1; step(); ack = 1'b0;
    got = int'(idx);
    chk("hs_gnt", 32'(gnt), 32'h1);
    vect = 1'b1; step(); step();
    vect = 1'b0; step();
    chk("hs_done_gnt", 32'(gnt), 32'h0);
  endtask

  int got;
  int rr_exp[4];

  initial begin
`ifdef INTR_ROUND_ROBIN_EN
    rr_exp = '{1, 3, 1, 3};
`else
    rr_exp = '{1, 1, 1, 1};
`endif
    repeat (2) step();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_req",  32'(req),  32'h0);
    chk("rst_gnt",  32'(gnt),  32'h0);
    chk("rst_idx",  32'(idx),  32'h0);
    rst = 1'b0; en = '1; step();

    // single channel, full sequence
    irq = 4'b0001; step();
    chk("s1_pend", 32'(pend), 32'h1);
    chk("s1_req0", 32'(req), 32'h0);
    step();
    chk("s1_req1", 32'(req), 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s1_gnt", 32'(gnt), 32'h1);
    chk("s1_idx", 32'(idx), 32'h0);
    chk("s1_req_off", 32'(req), 32'h0);
    vect = 1'b1;
    repeat (3) begin step(); chk("s1_gnt_vect", 32'(gnt), 32'h1); end
    vect = 1'b0; step();
    chk("s1_done_gnt", 32'(gnt), 32'h0);
    chk("s1_done_pend", 32'(pend), 32'h1);
    step();
    chk("s1_clr_pend", 32'(pend), 32'h0);
    step(); step();
    chk("s1_wait_pend", 32'(pend), 32'h0);
    chk("s1_wait_req", 32'(req), 32'h0);
    irq = '0; step(); step();

    // two simultaneous channels
    irq = 4'b1010;
    hs(got); chk("s2_idx_a", 32'(got), 32'h1);
    chk("s2_gap_done", 32'(req), 32'h0);
    step(); chk("s2_gap_idle", 32'(req), 32'h0);
    step(); chk("s2_req_again", 32'(req), 32'h1);
    hs(got); chk("s2_idx_b", 32'(got), 32'h3);
    irq = '0; repeat (3) step();
    chk("s2_idle_pend", 32'(pend), 32'h0);

    // retriggering channels 1 and 3
    irq = 4'b1010;
    for (int r = 0; r < 4; r++) begin
      hs(got);
      chk("s3_idx_seq", 32'(got), 32'(rr_exp[r]));
      irq[got] = 1'b0; step(); step();
      irq[got] = 1'b1; step();
    end
    irq = '0; clr = 1'b1; step(); clr = 1'b0;
    chk("clr_pend", 32'(pend), 32'h0);
    chk("clr_req",  32'(req),  32'h0);
    chk("clr_idx",  32'(idx),  32'h0);

    // granted channel disabled mid-handshake
    irq = 4'b0001;
    wait_req();
    ack = 1'b1; step(); ack = 1'b0;
    chk("s4_idx", 32'(idx), 32'h0);
    en = 4'b1110; irq = 4'b0101; step();
    chk("s4_pend", 32'(pend), 32'h4);
    chk("s4_gnt_hold", 32'(gnt), 32'h1);
    vect = 1'b1; step(); chk("s4_gnt_vect", 32'(gnt), 32'h1);
    vect = 1'b0; step(); step();
    chk("s4_other_kept", 32'(pend), 32'h4);
    hs(got); chk("s4_idx2", 32'(got), 32'h2);
    en = '1; irq = '0; repeat (3) step();

    // ack after pending vanished
    irq = 4'b0001;
    wait_req();
    en = '0; step();
    chk("s6_pend", 32'(pend), 32'h0);
    chk("s6_req_hold", 32'(req), 32'h1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("s6_req", 32'(req), 32'h0);
    chk("s6_gnt", 32'(gnt), 32'h0);
    step(); chk("s6_gnt2", 32'(gnt), 32'h0);
    en = '1; irq = '0; step();

    // async reset during VECTCLR
    irq = 4'b0010;
    wait_req();
    ack = 1'b1; step(); ack = 1'b0;
    vect = 1'b1; step();
    chk("s5_gnt", 32'(gnt), 32'h1);
    chk("s5_idx_pre", 32'(idx), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("s5_req", 32'(req), 32'h0);
    chk("s5_gnt0", 32'(gnt), 32'h0);
    chk("s5_pend", 32'(pend), 32'h0);
    chk("s5_idx", 32'(idx), 32'h0);
    vect = 1'b0;
    step(); step();
    rst = 1'b0; step();
    chk("s5_re_pend", 32'(pend), 32'h2);
    step(); chk("s5_re_req", 32'(req), 32'h1);
    hs(got); chk("s5_re_idx", 32'(got), 32'h1);
    irq = '0; repeat (3) step();

    // randomized phase
    for (int c = 0; c < 600; c++) begin
      en   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '1;
      for (int b = 0; b < NCH; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      ack  = ($urandom_range(0, 2) == 0);
      vect = ($urandom_range(0, 1) == 0);
      clr  = ($urandom_range(0, 60) == 0);
      step();
    end
    en = '1; irq = '0; ack = 1'b0; vect = 1'b0; clr = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dz_intr_arb.md
Name: dz_intr_arb

Overview:
- Parametrised N-channel interrupt controller for the DZ11 and similar multi-source UNIBUS peripherals.
- Each channel tracks a level-sensitive interrupt condition through IDLE/ACT/WAIT.
- A shared arbiter raises one bus request, runs the ack/vector handshake, and presents the winning channel index for vector formation.
- When the vector cycle ends, the arbiter clears the winning channel.

Parameters:
- NCH, 2, number of interrupt channels (2..16).
- IDXW, 1, width of the channel index; must equal max(1, ceil(log2(NCH))).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear (device clear / bus INIT); returns all state machines to IDLE
- en  in  NCH  per-channel interrupt enable
- irq  in  NCH  per-channel level interrupt condition
- ack  in  1  interrupt acknowledge from bus arbiter
- vect  in  1  interrupt vector read cycle active
- pend  out  NCH  per-channel pending (channel state == ACT)
- req  out  1  interrupt request to bus
- idx  out  IDXW  index of granted channel, valid while gnt=1
- gnt  out  1  grant latched (arbiter in VECT or VECTCLR)

Behaviour:
- Reset/clr: all channels IDLE, arbiter IDLE.
  - Outputs on reset: pend=0, req=0, gnt=0, idx=0.
  - clr has priority over all transitions except rst.
- Channel FSM (each channel i, all registered):
  - en[i]=0 forces IDLE next cycle, overriding everything else.
  - IDLE -> ACT when irq[i]=1.
  - ACT -> WAIT when done_i, i.e. arbiter in DONE with latched index == i.
  - WAIT -> IDLE when irq[i]=0. This gives one interrupt per rising condition.
- Arbiter FSM, states IDLE, REQ, VECT, VECTCLR, DONE:
  - IDLE -> REQ when any pend=1.
  - REQ -> VECT on ack.
    - In the same edge, latch idx = highest-priority pending channel (fixed priority: lowest index wins).
    - If no channel is pending at the ack edge, go to IDLE instead; ack is ignored.
  - VECT -> VECTCLR on vect=1.
  - VECTCLR -> DONE on vect=0.
  - DONE -> IDLE unconditionally after one cycle. done_i is asserted for that single cycle only.
- Outputs:
  - req = (state==REQ).
  - gnt = (state==VECT or VECTCLR).
  - idx holds its latched value from ack until the next latch.
- Latency: irq rise to pend is 1 clk; pend to req is 1 clk.
- Granted channel disabled mid-handshake:
  - The handshake still completes.
  - DONE clears nothing, because that channel is already IDLE.
  - The bus cycle is never aborted.
- A new irq on another channel during a handshake waits; it is serviced after DONE -> IDLE -> REQ.
- A channel whose irq stays high after clearing stays in WAIT and does not re-request until irq falls.
- ack or vect outside their expected states: ignored.

Optional Feature:
- Macro: INTR_ROUND_ROBIN_EN.
- Defined:
  - idx is selected round-robin.
  - A last-served pointer (IDXW bits, reset 0) updates to idx on entry to DONE.
  - Search starts at pointer+1 modulo NCH and wraps.
- Undefined: fixed priority, lowest index wins; no pointer register.

Decomposition:
- Shared package holds:
  - the arbiter state encoding (3-bit: IDLE=0, REQ=1, VECT=2, VECTCLR=3, DONE=4);
  - the channel state encoding (2-bit: IDLE=0, ACT=1, WAIT=2);
  - a priority-select function (mask in, index out).
- One sub-module, dz_intr_chan (single-channel IDLE/ACT/WAIT FSM), instantiated NCH times by generate.

Test Plan:
- NCH=2, en=11, irq=01:
  - pend=01 after 1 clk, req=1 after 2 clks.
  - ack -> idx=0, gnt=1.
  - vect pulse of 3 clks, then low -> DONE; pend=00; channel 0 in WAIT until irq[0]=0.
- NCH=4, irq=1010 simultaneous, fixed priority:
  - first handshake idx=1, second handshake idx=3.
  - req drops for 2 clks between handshakes (DONE, IDLE).
- Same stimulus with INTR_ROUND_ROBIN_EN, irq held re-triggering on channels 1 and 3:
  - successive idx sequence 1, 3, 1, 3.
- en[0] dropped while arbiter in VECT with idx=0:
  - handshake completes, gnt=1 through vect.
  - pend[0]=0 next clk; no spurious clear of other channels.
- rst asserted asynchronously in VECTCLR:
  - req, gnt, pend, idx all 0 immediately, without waiting for a clock edge.
  - After release with irq held, the full sequence restarts.
- ack with pend=0 (channel disabled during REQ): arbiter returns to IDLE, gnt never asserts.
